sync_fifo_wconv: RTL and testbench
==================================

SYNC_FIFO_WCONV -- requirements
Module: sync_fifo_wconv

Interface
REQ-001 SHALL have parameter DATA_WIDTH_I, default 256: write word width in bits.
REQ-002 SHALL have parameter DATA_WIDTH_O, default 64: read word width in bits.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8: capacity in words of max(DATA_WIDTH_I, DATA_WIDTH_O); power of 2, >=2.
REQ-004 SHALL have parameter OUTPUT_MODE, default 0: 0 = combinational fifo_dout, 1 = registered fifo_dout.
REQ-005 SHALL have parameter AFULL_TH, default 28: almost-full threshold in units of W_MIN.
REQ-006 SHALL have parameter AEMPTY_TH, default 4: almost-empty threshold in units of W_MIN.
REQ-007 SHALL define the derived values W_MIN = min(I,O), UI = I/W_MIN, UO = O/W_MIN, CAP = FIFO_DEPTH*max(UI,UO); max(I,O)/min(I,O) SHALL be a power of 2, and any other ratio SHALL be a parameter error.
REQ-008 SHALL have ports:
  clk  in  1  clock, rising edge.
  rst_n  in  1  reset; one clock; asynchronous, active-low.
  fifo_wr  in  1  write request.
  fifo_din  in  DATA_WIDTH_I  write data.
  fifo_full  out  1  write not accepted this cycle.
  fifo_afull  out  1  level >= AFULL_TH.
  fifo_rd  in  1  read request.
  fifo_dout  out  DATA_WIDTH_O  read data.
  fifo_empty  out  1  read not accepted this cycle.
  fifo_aempty  out  1  level <= AEMPTY_TH.
  fifo_level  out  clog2(CAP)+1  stored W_MIN units.
  err_clr  in  1  synchronous clear of the error flags.
  fifo_ovf  out  1  sticky overflow flag: write attempted while full.
  fifo_udf  out  1  sticky underflow flag: read attempted while empty.

Function
REQ-009 Storage SHALL be CAP slots of W_MIN bits with wrapping write and read pointers, each advancing modulo CAP.
REQ-010 An accepted write (fifo_wr & !fifo_full) SHALL store UI units; fifo_din[W_MIN-1:0] SHALL be the first unit to be read.
REQ-011 An accepted read (fifo_rd & !fifo_empty) SHALL remove UO units; the oldest unit SHALL occupy fifo_dout[W_MIN-1:0].
REQ-012 fifo_full SHALL be asserted when CAP - fifo_level < UI, and fifo_empty SHALL be asserted when fifo_level < UO; both SHALL be derived combinationally from registered level.
REQ-013 On a simultaneous accepted read and write, fifo_level SHALL become level + UI - UO in the same edge.
REQ-014 Acceptance SHALL be judged on pre-edge flags, so a write while full SHALL be ignored even if a read in the same cycle frees space.
REQ-015 A rejected write SHALL not change memory, pointers or level, and SHALL set fifo_ovf at the next edge.
REQ-016 A rejected read SHALL not change pointers or level, and SHALL set fifo_udf at the next edge.
REQ-017 err_clr SHALL clear fifo_ovf and fifo_udf; a new error in the same cycle as err_clr SHALL win, leaving the flag set.
REQ-018 In OUTPUT_MODE 0, fifo_dout SHALL show the head UO units combinationally whenever !fifo_empty, and SHALL be don't-care when empty.
REQ-019 In OUTPUT_MODE 1, fifo_dout SHALL load the popped word at the edge accepting the read (one-cycle latency) and SHALL hold otherwise.
REQ-020 fifo_afull and fifo_aempty SHALL be combinational compares on fifo_level.

Reset
REQ-021 While rst_n = 0: pointers and fifo_level SHALL be 0; fifo_empty = 1, fifo_aempty = 1, fifo_full = 0, fifo_afull = 0, fifo_ovf = 0, fifo_udf = 0, registered fifo_dout = 0.
REQ-022 Reset asserted mid-operation SHALL discard all contents immediately, without waiting for a clock edge.
REQ-023 Memory contents SHALL not require reset.

Verification (defaults: I=256, O=64, depth 8, CAP=32 units)
REQ-024 Write 8 words, where word k = {64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF} - k -> fifo_full=1, fifo_level=32, fifo_afull=1; then read 32 times -> dout order is the slices [63:0], [127:64], [191:128], [255:192] of each word in turn, ending with fifo_empty=1.
REQ-025 Hold level at 30 and assert wr and rd together -> write rejected (30 > 32-4 fails space check), fifo_ovf=1, level becomes 29.
REQ-026 Read on reset-empty FIFO -> fifo_udf=1 and level stays 0; err_clr pulse -> fifo_udf=0.
REQ-027 OUTPUT_MODE=1, write 1 word, read once -> fifo_dout equals the low 64 bits one edge after the read and holds through 5 idle cycles.
REQ-028 Narrow-to-wide configuration (I=64, O=256): write 3 units -> fifo_empty=1; write a 4th unit -> fifo_empty=0, and fifo_dout = {w3, w2, w1, w0}.
REQ-029 Assert rst_n=0 at level 17, between clock edges -> fifo_level=0 and fifo_empty=1 before the next edge.

Source files
------------

// File: rtl/sync_fifo_wconv_if.sv
// Bus bundle for the width-converting synchronous FIFO.
// The master side writes/reads; the slave side is the FIFO itself.
interface sync_fifo_wconv_if #(
    parameter int DATA_WIDTH_I = 256,
    parameter int DATA_WIDTH_O = 64,
    parameter int FIFO_DEPTH   = 8
);
    localparam int W_MIN = (DATA_WIDTH_I < DATA_WIDTH_O) ? DATA_WIDTH_I : DATA_WIDTH_O;
    localparam int W_MAX = (DATA_WIDTH_I < DATA_WIDTH_O) ? DATA_WIDTH_O : DATA_WIDTH_I;
    localparam int CAP   = FIFO_DEPTH * (W_MAX / W_MIN);
    localparam int LVL_W = $clog2(CAP) + 1;

    logic                    fifo_wr;
    logic [DATA_WIDTH_I-1:0] fifo_din;
    logic                    fifo_full;
    logic                    fifo_afull;
    logic                    fifo_rd;
    logic [DATA_WIDTH_O-1:0] fifo_dout;
    logic                    fifo_empty;
    logic                    fifo_aempty;
    logic [LVL_W-1:0]        fifo_level;
    logic                    err_clr;
    logic                    fifo_ovf;
    logic                    fifo_udf;

    modport master (
        output fifo_wr, fifo_din, fifo_rd, err_clr,
        input  fifo_full, fifo_afull, fifo_dout, fifo_empty, fifo_aempty,
               fifo_level, fifo_ovf, fifo_udf
    );

    modport slave (
        input  fifo_wr, fifo_din, fifo_rd, err_clr,
        output fifo_full, fifo_afull, fifo_dout, fifo_empty, fifo_aempty,
               fifo_level, fifo_ovf, fifo_udf
    );
endinterface

// File: rtl/sync_fifo_wconv.sv
// Synchronous FIFO with independent write and read widths.
// Storage is a ring of CAP slots, each one W_MIN-bit unit wide; a write
// deposits UI units and a read removes UO units. Occupancy is counted in units.
module sync_fifo_wconv #(
    parameter int DATA_WIDTH_I = 256,
    parameter int DATA_WIDTH_O = 64,
    parameter int FIFO_DEPTH   = 8,
    parameter int OUTPUT_MODE  = 0,
    parameter int AFULL_TH     = 28,
    parameter int AEMPTY_TH    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    sync_fifo_wconv_if.slave bus
);
    localparam int W_MIN = (DATA_WIDTH_I < DATA_WIDTH_O) ? DATA_WIDTH_I : DATA_WIDTH_O;
    localparam int W_MAX = (DATA_WIDTH_I < DATA_WIDTH_O) ? DATA_WIDTH_O : DATA_WIDTH_I;
    localparam int RATIO = W_MAX / W_MIN;
    localparam int UI    = DATA_WIDTH_I / W_MIN;
    localparam int UO    = DATA_WIDTH_O / W_MIN;
    localparam int CAP   = FIFO_DEPTH * RATIO;
    localparam int PTR_W = $clog2(CAP);
    localparam int LVL_W = PTR_W + 1;

    // Width ratio must be an exact power of two so unit slots tile both words.
    if ((W_MAX % W_MIN) != 0 || (RATIO & (RATIO - 1)) != 0) begin : g_bad_ratio
        $error("sync_fifo_wconv: width ratio must be a power of 2");
    end
    // Depth must be a power of two so pointers wrap naturally modulo CAP.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo_wconv: FIFO_DEPTH must be a power of 2 and >= 2");
    end

    logic [W_MIN-1:0]        mem_q [CAP];
    logic [PTR_W-1:0]        wptr_q, wptr_d;
    logic [PTR_W-1:0]        rptr_q, rptr_d;
    logic [LVL_W-1:0]        level_q, level_d;
    logic                    ovf_q, ovf_d;
    logic                    udf_q, udf_d;
    logic [DATA_WIDTH_O-1:0] dout_q, dout_d;
    logic [DATA_WIDTH_O-1:0] head_s;
    logic                    full_s, empty_s;
    logic                    wr_acc_s, rd_acc_s;

    // Space/data availability from the registered level; acceptance uses these pre-edge flags.
    always_comb begin
        full_s   = (LVL_W'(CAP) - level_q) < LVL_W'(UI);
        empty_s  = level_q < LVL_W'(UO);
        wr_acc_s = bus.fifo_wr & ~full_s;
        rd_acc_s = bus.fifo_rd & ~empty_s;
    end

    // Gather the UO oldest units into an output word, oldest in the low slice.
    always_comb begin
        head_s = {DATA_WIDTH_O{1'b0}};
        for (int u = 0; u < UO; u++) begin
            head_s[u*W_MIN +: W_MIN] = mem_q[rptr_q + PTR_W'(u)];
        end
    end

    // Next-state for pointers, level, sticky error flags and the registered output word.
    always_comb begin
        if (wr_acc_s) begin
            wptr_d = wptr_q + PTR_W'(UI);
        end else begin
            wptr_d = wptr_q;
        end

        if (rd_acc_s) begin
            rptr_d = rptr_q + PTR_W'(UO);
            dout_d = head_s;
        end else begin
            rptr_d = rptr_q;
            dout_d = dout_q;
        end

        level_d = level_q
                + (wr_acc_s ? LVL_W'(UI) : {LVL_W{1'b0}})
                - (rd_acc_s ? LVL_W'(UO) : {LVL_W{1'b0}});

        // A fresh error outranks a clear in the same cycle.
        if (bus.fifo_wr & full_s) begin
            ovf_d = 1'b1;
        end else if (bus.err_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        if (bus.fifo_rd & empty_s) begin
            udf_d = 1'b1;
        end else if (bus.err_clr) begin
            udf_d = 1'b0;
        end else begin
            udf_d = udf_q;
        end
    end

    // Control state; reset discards contents immediately by zeroing pointers and level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= {PTR_W{1'b0}};
            rptr_q  <= {PTR_W{1'b0}};
            level_q <= {LVL_W{1'b0}};
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            dout_q  <= {DATA_WIDTH_O{1'b0}};
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            dout_q  <= dout_d;
        end
    end

    // Unit storage: no reset needed, contents are only visible through valid pointers.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            for (int u = 0; u < UI; u++) begin
                mem_q[wptr_q + PTR_W'(u)] <= bus.fifo_din[u*W_MIN +: W_MIN];
            end
        end
    end

    assign bus.fifo_full   = full_s;
    assign bus.fifo_empty  = empty_s;
    assign bus.fifo_afull  = int'(level_q) >= AFULL_TH;
    assign bus.fifo_aempty = int'(level_q) <= AEMPTY_TH;
    assign bus.fifo_level  = level_q;
    assign bus.fifo_ovf    = ovf_q;
    assign bus.fifo_udf    = udf_q;
    assign bus.fifo_dout   = (OUTPUT_MODE != 0) ? dout_q : head_s;

endmodule

// File: tb/tb_sync_fifo_wconv.sv
// Bench for sync_fifo_wconv: three instances (wide->narrow combinational,
// wide->narrow registered, narrow->wide) checked against a unit-queue model.
module tb_sync_fifo_wconv;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sync_fifo_wconv_if #(.DATA_WIDTH_I(256), .DATA_WIDTH_O(64),  .FIFO_DEPTH(8)) a_if ();
    sync_fifo_wconv_if #(.DATA_WIDTH_I(256), .DATA_WIDTH_O(64),  .FIFO_DEPTH(8)) b_if ();
    sync_fifo_wconv_if #(.DATA_WIDTH_I(64),  .DATA_WIDTH_O(256), .FIFO_DEPTH(8)) c_if ();

    sync_fifo_wconv #(.DATA_WIDTH_I(256), .DATA_WIDTH_O(64), .FIFO_DEPTH(8),
                      .OUTPUT_MODE(0), .AFULL_TH(28), .AEMPTY_TH(4))
        u_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
    sync_fifo_wconv #(.DATA_WIDTH_I(256), .DATA_WIDTH_O(64), .FIFO_DEPTH(8),
                      .OUTPUT_MODE(1), .AFULL_TH(28), .AEMPTY_TH(4))
        u_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));
    sync_fifo_wconv #(.DATA_WIDTH_I(64), .DATA_WIDTH_O(256), .FIFO_DEPTH(8),
                      .OUTPUT_MODE(0), .AFULL_TH(28), .AEMPTY_TH(4))
        u_c (.clk(clk), .rst_n(rst_n), .bus(c_if.slave));

    logic         drv_wr  [3];
    logic         drv_rd  [3];
    logic         drv_clr [3];
    logic [255:0] drv_din [3];

    assign a_if.fifo_wr = drv_wr[0];  assign a_if.fifo_rd = drv_rd[0];
    assign a_if.err_clr = drv_clr[0]; assign a_if.fifo_din = drv_din[0];
    assign b_if.fifo_wr = drv_wr[1];  assign b_if.fifo_rd = drv_rd[1];
    assign b_if.err_clr = drv_clr[1]; assign b_if.fifo_din = drv_din[1];
    assign c_if.fifo_wr = drv_wr[2];  assign c_if.fifo_rd = drv_rd[2];
    assign c_if.err_clr = drv_clr[2]; assign c_if.fifo_din = drv_din[2][63:0];

    logic [5:0]   obs_level  [3];
    logic         obs_full   [3];
    logic         obs_empty  [3];
    logic         obs_afull  [3];
    logic         obs_aempty [3];
    logic         obs_ovf    [3];
    logic         obs_udf    [3];
    logic [255:0] obs_dout   [3];

    assign obs_level[0] = a_if.fifo_level; assign obs_level[1] = b_if.fifo_level;
    assign obs_level[2] = c_if.fifo_level;
    assign obs_full[0]  = a_if.fifo_full;  assign obs_full[1]  = b_if.fifo_full;
    assign obs_full[2]  = c_if.fifo_full;
    assign obs_empty[0] = a_if.fifo_empty; assign obs_empty[1] = b_if.fifo_empty;
    assign obs_empty[2] = c_if.fifo_empty;
    assign obs_afull[0] = a_if.fifo_afull; assign obs_afull[1] = b_if.fifo_afull;
    assign obs_afull[2] = c_if.fifo_afull;
    assign obs_aempty[0] = a_if.fifo_aempty; assign obs_aempty[1] = b_if.fifo_aempty;
    assign obs_aempty[2] = c_if.fifo_aempty;
    assign obs_ovf[0]   = a_if.fifo_ovf;   assign obs_ovf[1]   = b_if.fifo_ovf;
    assign obs_ovf[2]   = c_if.fifo_ovf;
    assign obs_udf[0]   = a_if.fifo_udf;   assign obs_udf[1]   = b_if.fifo_udf;
    assign obs_udf[2]   = c_if.fifo_udf;
    assign obs_dout[0]  = {192'd0, a_if.fifo_dout};
    assign obs_dout[1]  = {192'd0, b_if.fifo_dout};
    assign obs_dout[2]  = c_if.fifo_dout;

    // Reference model: each FIFO is a queue of 64-bit units.
    localparam int CAPM = 32;
    int          ui_of [3] = '{4, 4, 1};
    int          uo_of [3] = '{1, 1, 4};
    logic [63:0] mq    [3][$];
    logic        m_ovf [3];
    logic        m_udf [3];
    logic [63:0] m_dout1;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic check_state(input int i, input string tag);
        int n;
        logic [255:0] exp;
        n = mq[i].size();
        chk($sformatf("%s.d%0d.level", tag, i),  256'(obs_level[i]),  256'(n));
        chk($sformatf("%s.d%0d.full", tag, i),   256'(obs_full[i]),   256'((CAPM - n) < ui_of[i]));
        chk($sformatf("%s.d%0d.empty", tag, i),  256'(obs_empty[i]),  256'(n < uo_of[i]));
        chk($sformatf("%s.d%0d.afull", tag, i),  256'(obs_afull[i]),  256'(n >= 28));
        chk($sformatf("%s.d%0d.aempty", tag, i), 256'(obs_aempty[i]), 256'(n <= 4));
        chk($sformatf("%s.d%0d.ovf", tag, i),    256'(obs_ovf[i]),    256'(m_ovf[i]));
        chk($sformatf("%s.d%0d.udf", tag, i),    256'(obs_udf[i]),    256'(m_udf[i]));
        if (i == 1) begin
            chk($sformatf("%s.d1.dout_reg", tag), obs_dout[1], 256'(m_dout1));
        end else if (n >= uo_of[i]) begin
            exp = '0;
            for (int u = 0; u < uo_of[i]; u++) exp[u*64 +: 64] = mq[i][u];
            chk($sformatf("%s.d%0d.dout", tag, i), obs_dout[i], exp);
        end
    endtask

    // One clock cycle on FIFO i; called and returning at posedge+1.
    task automatic cyc(input int i, input bit wr, input bit rd, input bit clr,
                       input logic [255:0] din, input string tag);
        int n;
        bit full, empty;
        logic [255:0] pw;
        for (int k = 0; k < 3; k++) begin
            drv_wr[k] = 1'b0; drv_rd[k] = 1'b0; drv_clr[k] = 1'b0; drv_din[k] = '0;
        end
        drv_wr[i] = wr; drv_rd[i] = rd; drv_clr[i] = clr; drv_din[i] = din;
        n     = mq[i].size();
        full  = (CAPM - n) < ui_of[i];
        empty = n < uo_of[i];
        @(posedge clk);
        #1;
        pw = '0;
        if (rd && !empty) begin
            for (int u = 0; u < uo_of[i]; u++) pw[u*64 +: 64] = mq[i].pop_front();
            if (i == 1) m_dout1 = pw[63:0];
        end
        if (wr && !full) begin
            for (int u = 0; u < ui_of[i]; u++) mq[i].push_back(din[u*64 +: 64]);
        end
        m_ovf[i] = (wr && full)  ? 1'b1 : (clr ? 1'b0 : m_ovf[i]);
        m_udf[i] = (rd && empty) ? 1'b1 : (clr ? 1'b0 : m_udf[i]);
        drv_wr[i] = 1'b0; drv_rd[i] = 1'b0; drv_clr[i] = 1'b0;
        check_state(i, tag);
    endtask

    // Assert reset away from an edge and check every instance before any clock.
    task automatic reset_all(input string tag);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            mq[i].delete();
            m_ovf[i] = 1'b0;
            m_udf[i] = 1'b0;
        end
        m_dout1 = '0;
        for (int i = 0; i < 3; i++) check_state(i, tag);
    endtask

    initial begin
        logic [255:0] base, word, w;
        logic [63:0]  u0, u1, u2, u3;
        int           wp, rp;

        for (int k = 0; k < 3; k++) begin
            drv_wr[k] = 1'b0; drv_rd[k] = 1'b0; drv_clr[k] = 1'b0; drv_din[k] = '0;
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_all("por");
        rst_n = 1'b1;

        // Read on empty FIFO sets underflow; err_clr clears it.
        cyc(0, 1'b0, 1'b1, 1'b0, '0, "udf_rd");
        chk("udf_set", 256'(obs_udf[0]), 256'(1));
        chk("udf_level0", 256'(obs_level[0]), 256'(0));
        cyc(0, 1'b0, 1'b0, 1'b1, '0, "udf_clr");
        chk("udf_cleared", 256'(obs_udf[0]), 256'(0));

        // Fill with the patterned words, check full flags.
        base = {64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
        for (int k = 0; k < 8; k++) cyc(0, 1'b1, 1'b0, 1'b0, base - 256'(k), "fill");
        chk("fill_full", 256'(obs_full[0]), 256'(1));
        chk("fill_level", 256'(obs_level[0]), 256'(32));
        chk("fill_afull", 256'(obs_afull[0]), 256'(1));

        // Overflow raised in the same cycle as err_clr must stay set.
        cyc(0, 1'b1, 1'b0, 1'b1, '1, "ovf_vs_clr");
        chk("ovf_wins", 256'(obs_ovf[0]), 256'(1));
        cyc(0, 1'b0, 1'b0, 1'b1, '0, "ovf_clr");
        chk("ovf_cleared", 256'(obs_ovf[0]), 256'(0));

        // Drain: 64-bit slices come out low slice first, word by word.
        for (int j = 0; j < 32; j++) begin
            word = base - 256'(j / 4);
            chk($sformatf("drain_order_%0d", j), obs_dout[0], 256'(word[(j % 4)*64 +: 64]));
            cyc(0, 1'b0, 1'b1, 1'b0, '0, "drain");
        end
        chk("drain_empty", 256'(obs_empty[0]), 256'(1));

        // Level 30: write is rejected on pre-edge full, read still proceeds.
        for (int k = 0; k < 8; k++) cyc(0, 1'b1, 1'b0, 1'b0, rnd256(), "to30_w");
        cyc(0, 1'b0, 1'b1, 1'b0, '0, "to30_r");
        cyc(0, 1'b0, 1'b1, 1'b0, '0, "to30_r");
        chk("at30", 256'(obs_level[0]), 256'(30));
        cyc(0, 1'b1, 1'b1, 1'b0, rnd256(), "both30");
        chk("both30_level", 256'(obs_level[0]), 256'(29));
        chk("both30_ovf", 256'(obs_ovf[0]), 256'(1));

        // Reset asserted between edges at level 17.
        repeat (12) cyc(0, 1'b0, 1'b1, 1'b0, '0, "to17");
        chk("at17", 256'(obs_level[0]), 256'(17));
        #2;
        reset_all("midreset");
        chk("midreset_level", 256'(obs_level[0]), 256'(0));
        chk("midreset_empty", 256'(obs_empty[0]), 256'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Registered output: popped word appears after the edge and holds.
        w = rnd256();
        cyc(1, 1'b1, 1'b0, 1'b0, w, "reg_w");
        cyc(1, 1'b0, 1'b1, 1'b0, '0, "reg_r");
        chk("reg_dout", obs_dout[1], 256'(w[63:0]));
        for (int k = 0; k < 5; k++) begin
            cyc(1, 1'b0, 1'b0, 1'b0, '0, "reg_idle");
            chk($sformatf("reg_hold_%0d", k), obs_dout[1], 256'(w[63:0]));
        end

        // Narrow-to-wide: three units still empty, fourth completes a word.
        u0 = {$urandom, $urandom}; u1 = {$urandom, $urandom};
        u2 = {$urandom, $urandom}; u3 = {$urandom, $urandom};
        cyc(2, 1'b1, 1'b0, 1'b0, 256'(u0), "n2w");
        cyc(2, 1'b1, 1'b0, 1'b0, 256'(u1), "n2w");
        cyc(2, 1'b1, 1'b0, 1'b0, 256'(u2), "n2w");
        chk("n2w_empty3", 256'(obs_empty[2]), 256'(1));
        cyc(2, 1'b1, 1'b0, 1'b0, 256'(u3), "n2w");
        chk("n2w_empty4", 256'(obs_empty[2]), 256'(0));
        chk("n2w_dout", obs_dout[2], {u3, u2, u1, u0});

        // Randomized traffic on every instance, write-heavy then read-heavy.
        for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < 400; c++) begin
                wp = ((c / 100) % 2 == 0) ? 75 : 30;
                rp = 100 - wp;
                cyc(i, $urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
                    $urandom_range(0, 15) == 0, rnd256(), "rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
